// File: rtl/palette_pkg.sv
// Shared widths, defaults and RGB layout for the palette LUT pipeline.
package palette_pkg;

  localparam int unsigned ITER_W_DEF    = 8;
  localparam int unsigned COLOR_W_DEF   = 8;
  localparam int unsigned NUM_BANKS_DEF = 4;

  // RGB word layout: r in the top third, b in the bottom third.
  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } rgb_t;

  // Width of a packed {r,g,b} word.
  function automatic int unsigned rgb_width(input int unsigned color_w);
    return 3 * color_w;
  endfunction

  // Bank select width; never narrower than one bit.
  function automatic int unsigned bank_width(input int unsigned num_banks);
    return (num_banks <= 1) ? 1 : $clog2(num_banks);
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port palette RAM: one write port, one registered read port.
// The read returns the old word when it hits the address being written.
module palette_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read share an edge; NBA ordering gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/palette_lut_pipe.sv
// Two-stage iteration-count to RGB mapper with banked RAM palettes,
// programmable inside-set colour and per-frame rotation for colour cycling.
module palette_lut_pipe
  import palette_pkg::*;
#(
  parameter  int unsigned ITER_W    = ITER_W_DEF,
  parameter  int unsigned COLOR_W   = COLOR_W_DEF,
  parameter  int unsigned NUM_BANKS = NUM_BANKS_DEF,
  localparam int unsigned BANK_W    = bank_width(NUM_BANKS),
  localparam int unsigned RGB_W     = rgb_width(COLOR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ITER_W-1:0] in_iter,
  input  logic [ITER_W-1:0] max_iter,
  input  logic [BANK_W-1:0] bank_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RGB_W-1:0]  out_rgb,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ITER_W-1:0] wr_addr,
  input  logic [RGB_W-1:0]  wr_data,
  input  logic [RGB_W-1:0]  inside_rgb,
  input  logic              cycle_en,
  input  logic [ITER_W-1:0] cycle_step,
  input  logic              frame_tick,
  output logic [ITER_W-1:0] rot_offset
);

  localparam int unsigned ADDR_W = BANK_W + ITER_W;
  localparam int unsigned DEPTH  = NUM_BANKS << ITER_W;

  logic              adv;
  logic              rd_bank_ok;
  logic              wr_bank_ok;
  logic              ram_we;
  logic              v1;
  logic              inside1;
  logic [ITER_W-1:0] idx1;
  logic [BANK_W-1:0] bank1;
  logic              inside2;
  logic [RGB_W-1:0]  inside_q;
  logic [RGB_W-1:0]  lut_q;

  // Whole pipeline moves together unless the output is held by back-pressure.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Out-of-range banks: reads fall back to bank 0, writes are dropped.
  assign rd_bank_ok = 32'(bank_sel) < NUM_BANKS;
  assign wr_bank_ok = 32'(wr_bank) < NUM_BANKS;
  assign ram_we     = wr_en && wr_bank_ok;

  // Rotation offset for colour cycling, stepped once per enabled frame tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rot_offset <= '0;
    end else if (frame_tick && cycle_en) begin
      rot_offset <= rot_offset + cycle_step;
    end
  end

  // Stage 1: inside decision on the raw count, rotated LUT index, bank pick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      inside1 <= 1'b1;
      idx1    <= '0;
      bank1   <= '0;
    end else if (adv) begin
      v1      <= in_valid;
      inside1 <= (in_iter >= max_iter);
      idx1    <= in_iter + rot_offset;
      bank1   <= rd_bank_ok ? bank_sel : BANK_W'(0);
    end
  end

  // Stage 2: valid bit, inside flag and inside colour alongside the RAM read.
  // The inside flag resets high so out_rgb reads the cleared inside colour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      inside2   <= 1'b1;
      inside_q  <= '0;
    end else if (adv) begin
      out_valid <= v1;
      inside2   <= inside1;
      inside_q  <= inside_rgb;
    end
  end

  palette_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (RGB_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr ({wr_bank, wr_addr}),
    .wdata (wr_data),
    .re    (adv),
    .raddr ({bank1, idx1}),
    .rdata (lut_q)
  );

  // Final select between two stage-2 registers; the RAM output register stays in the macro.
  assign out_rgb = inside2 ? inside_q : lut_q;

endmodule
